// File: rtl/tc_pkg.sv
// Shared types and defaults for the shared one-shot delay scheduler.
// Holds the FSM state encoding plus default requester count and counter width.
package tc_pkg;

    localparam int TC_NREQ = 4;
    localparam int TC_CW   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tc_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans i_req from i_ptr upward with wrap.
// Ports: i_req (requests), i_ptr (first index to try), o_gnt (one-hot),
//        o_idx (granted index), o_valid (some request was found).
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    logic [IW-1:0] w_j;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = IW'((int'(i_ptr) + k) % NREQ);
            if (!o_valid && i_req[w_j]) begin
                o_valid    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/tc_delay_scheduler.sv
// One CW-bit delay counter shared by NREQ requesters, round-robin arbitrated.
// Ports: clk, reset_n (async low), req/req_tc (per-requester level request and
//        terminal count), gnt (one-hot owner), done (1-cycle pulse), busy, count.
module tc_delay_scheduler
    import tc_pkg::*;
#(
    parameter int NREQ = TC_NREQ,
    parameter int CW   = TC_CW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*CW-1:0] req_tc,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [CW-1:0]     count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    tc_state_t       r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_done, w_done_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [CW-1:0]   r_tc, w_tc_nxt;
    logic            r_match, w_match_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;

    logic [NREQ-1:0] w_arb_gnt;
    logic [IW-1:0]   w_arb_idx;
    logic            w_arb_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_count_nxt = r_count;
        w_tc_nxt    = r_tc;
        w_match_nxt = 1'b0;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = ST_RUN;
                    w_gnt_nxt   = w_arb_gnt;
                    w_tc_nxt    = req_tc[w_arb_idx*CW +: CW];
                    w_count_nxt = '0;
                    w_ptr_nxt   = (w_arb_idx == IW'(NREQ-1))
                                ? '0 : w_arb_idx + 1'b1;
                end
            end
            ST_RUN: begin
                // Owner dropping its request abandons the delay silently.
                if (~|(req & r_gnt)) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_count_nxt = '0;
                end else if (r_match) begin
                    w_state_nxt = ST_DONE;
                    w_gnt_nxt   = '0;
                    w_done_nxt  = r_gnt;
                end else begin
                    // Count saturates at TC so it can never wrap.
                    w_match_nxt = (r_count == r_tc);
                    if (r_count != r_tc)
                        w_count_nxt = r_count + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_count <= '0;
            r_tc    <= '0;
            r_match <= 1'b0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_match <= w_match_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign done  = r_done;
    assign busy  = (r_state != ST_IDLE);
    assign count = r_count;

endmodule

// File: tb/tb_tc_delay_scheduler.sv
// Scoreboard bench for tc_delay_scheduler: expected done pulses are queued
// when a request is driven and popped by a monitor when done fires.
module tb_tc_delay_scheduler;

    localparam int NREQ = 4;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*CW-1:0] req_tc;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [CW-1:0]     count;

    typedef struct {
        int idx;
        int at;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    tc_delay_scheduler #(
        .NREQ (NREQ),
        .CW   (CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .req_tc  (req_tc),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .count   (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Done monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (sb.size() > 0 && sb[0].at < cyc) begin
                e = sb.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL done_missing: no done[%0d] seen, required at cyc %0d",
                         e.idx, e.at);
            end
            if (done !== '0) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL done_unexpected: done=%b at cyc %0d, none required",
                             done, cyc);
                end else begin
                    e = sb.pop_front();
                    if (done !== NREQ'(1 << e.idx) || cyc != e.at || gnt !== '0) begin
                        n_err++;
                        $display("FAIL done_match: done=%b gnt=%b cyc=%0d, required done[%0d] gnt=0 cyc=%0d",
                                 done, gnt, cyc, e.idx, e.at);
                    end
                end
            end
        end
    end

    task automatic set_tc(input int idx, input int tc);
        req_tc[idx*CW +: CW] = CW'(tc);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = '0;
        req_tc  = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (gnt !== '0) begin
            n_err++; $display("FAIL reset_gnt: got %b required 0", gnt);
        end
        n_cmp++;
        if (done !== '0) begin
            n_err++; $display("FAIL reset_done: got %b required 0", done);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        n_cmp++;
        if (count !== '0) begin
            n_err++; $display("FAIL reset_count: got %0d required 0", count);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Single requester, full lifecycle checked every cycle.
    task automatic run_one(input int idx, input int tc);
        int e0;
        logic [CW-1:0] ec;
        @(negedge clk);
        set_tc(idx, tc);
        req[idx] = 1'b1;
        e0 = cyc + 1;
        sb.push_back('{idx, e0 + tc + 2});
        for (int k = 0; k <= tc + 1; k++) begin
            @(negedge clk);
            if (k == 1) set_tc(idx, (tc + 5) % 16);
            ec = CW'((k < tc) ? k : tc);
            n_cmp++;
            if (gnt !== NREQ'(1 << idx) || count !== ec || busy !== 1'b1) begin
                n_err++;
                $display("FAIL run_tc%0d_k%0d: gnt=%b count=%0d busy=%b, required gnt=%b count=%0d busy=1",
                         tc, k, gnt, count, busy, NREQ'(1 << idx), ec);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL done_cycle_tc%0d: gnt=%b busy=%b, required gnt=0 busy=1",
                     tc, gnt, busy);
        end
        req[idx] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0 || count !== '0 || done !== '0) begin
            n_err++;
            $display("FAIL idle_after_tc%0d: gnt=%b busy=%b count=%0d done=%b, required all 0",
                     tc, gnt, busy, count, done);
        end
    endtask

    // Three held requesters: grants rotate 0,1,3,0, one every TC+4 cycles.
    task automatic test_round_robin();
        int e0;
        int order[4];
        order = '{0, 1, 3, 0};
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_tc(i, 3);
        req = 4'b1011;
        e0  = cyc + 1;
        for (int n = 0; n < 4; n++) sb.push_back('{order[n], e0 + 7*n + 5});
        for (int t = 0; t <= 26; t++) begin
            @(negedge clk);
            for (int n = 0; n < 4; n++) begin
                if (t == 7*n) begin
                    n_cmp++;
                    if (gnt !== NREQ'(1 << order[n])) begin
                        n_err++;
                        $display("FAIL rr_grant%0d: gnt=%b required %b",
                                 n, gnt, NREQ'(1 << order[n]));
                    end
                end
            end
            if (t == 6 || t == 13 || t == 20) begin
                n_cmp++;
                if (gnt !== '0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL rr_idle_t%0d: gnt=%b busy=%b, required 0 0",
                             t, gnt, busy);
                end
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abandon();
        @(negedge clk);
        set_tc(1, 11);
        req[1] = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (count !== 4'd5 || gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL abandon_pre: count=%0d gnt=%b, required 5 0010", count, gnt);
        end
        req[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (gnt !== '0 || count !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abandon_idle: gnt=%b count=%0d busy=%b, required 0 0 0",
                     gnt, count, busy);
        end
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int e0;
        @(negedge clk);
        set_tc(2, 11);
        req[2] = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (count !== 4'd7) begin
            n_err++;
            $display("FAIL rst_pre_count: got %0d required 7", count);
        end
        req = 4'b1101;
        set_tc(0, 2);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== '0 || done !== '0 || busy !== 1'b0 || count !== '0) begin
            n_err++;
            $display("FAIL rst_async: gnt=%b done=%b busy=%b count=%0d, required all 0",
                     gnt, done, busy, count);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        e0 = cyc + 1;
        sb.push_back('{0, e0 + 4});
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_first_grant: gnt=%b required 0001", gnt);
        end
        req = 4'b0001;
        repeat (4) @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        run_one(0, 11);
        run_one(2, 0);
        run_one(3, 15);
        test_abandon();
        test_reset_mid_run();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d done pulses outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
